// File: rtl/nmr_ctrl_pkg.sv
// Shared definitions for the NMR scan sequencer.
// One-hot state encoding and default widths/timeouts.
package nmr_ctrl_pkg;

    localparam int DATABUS_WIDTH_DEF  = 32;
    localparam int LAUNCH_TIMEOUT_DEF = 64;

    localparam int I_IDLE   = 0;
    localparam int I_ARM    = 1;
    localparam int I_LAUNCH = 2;
    localparam int I_RUN    = 3;
    localparam int I_REPDLY = 4;
    localparam int I_NEXT   = 5;
    localparam int I_FINISH = 6;

    typedef enum logic [6:0] {
        S_IDLE   = 7'b0000001,
        S_ARM    = 7'b0000010,
        S_LAUNCH = 7'b0000100,
        S_RUN    = 7'b0001000,
        S_REPDLY = 7'b0010000,
        S_NEXT   = 7'b0100000,
        S_FINISH = 7'b1000000
    } state_t;

endpackage

// File: rtl/nmr_scan_sequencer_if.sv
// Host control/status and pulse-program engine signals
// of the scan sequencer, bundled for port connection.
interface nmr_scan_sequencer_if
#(
    parameter int DATABUS_WIDTH = nmr_ctrl_pkg::DATABUS_WIDTH_DEF
);
    logic                     START;
    logic                     ABORT;
    logic [DATABUS_WIDTH-1:0] SCAN_COUNT;
    logic [DATABUS_WIDTH-1:0] REP_DELAY;
    logic                     PHCYC_EN;
    logic                     PP_FSMSTAT;
    logic                     PP_START;
    logic                     PHASE_CYC;
    logic                     BUSY;
    logic                     DONE;
    logic                     ABORTED;
    logic                     TIMEOUT_ERR;
    logic [DATABUS_WIDTH-1:0] SCAN_IDX;

    modport master (
        output START, ABORT, SCAN_COUNT, REP_DELAY,
        output PHCYC_EN, PP_FSMSTAT,
        input  PP_START, PHASE_CYC, BUSY, DONE,
        input  ABORTED, TIMEOUT_ERR, SCAN_IDX
    );

    modport slave (
        input  START, ABORT, SCAN_COUNT, REP_DELAY,
        input  PHCYC_EN, PP_FSMSTAT,
        output PP_START, PHASE_CYC, BUSY, DONE,
        output ABORTED, TIMEOUT_ERR, SCAN_IDX
    );

endinterface

// File: rtl/nmr_down_counter.sv
// Loadable down counter with zero flag; shared between
// the repetition delay and the launch timeout.
module nmr_down_counter
#(
    parameter int W = 32
)
(
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // load has priority; decrement saturates at zero
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/nmr_scan_sequencer.sv
// Multi-scan run sequencer driving the pulse-program
// engine: launch, wait, repetition delay, next scan.
module nmr_scan_sequencer
#(
    parameter int DATABUS_WIDTH  = nmr_ctrl_pkg::DATABUS_WIDTH_DEF,
    parameter int LAUNCH_TIMEOUT = nmr_ctrl_pkg::LAUNCH_TIMEOUT_DEF
)
(
    input logic                 CLK,
    input logic                 RESET_N,
    nmr_scan_sequencer_if.slave bus
);
    import nmr_ctrl_pkg::*;

    localparam int W = DATABUS_WIDTH;
    localparam logic [W-1:0] TMO_LOAD = W'(LAUNCH_TIMEOUT - 1);

    state_t       state;
    state_t       nxt;
    logic [W-1:0] scnt_q;
    logic [W-1:0] rdly_q;
    logic         phen_q;
    logic [W-1:0] idx_q;
    logic         phase_q;
    logic         pp_start_q;
    logic         busy_q;
    logic         done_q;
    logic         aborted_q;
    logic         tmo_err_q;
    logic         abort_q;
    logic         abort_eff;
    logic         last_scan;
    logic         cnt_load;
    logic         cnt_dec;
    logic [W-1:0] cnt_val;
    logic         cnt_zero;

    assign abort_eff = abort_q | bus.ABORT;
    assign last_scan = ((idx_q + W'(1)) == scnt_q);

    nmr_down_counter #(.W(W)) u_cnt (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= nxt;
    end

    // next state and counter control
    always_comb begin
        nxt      = state;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        unique case (1'b1)
            state[I_IDLE]: begin
                if (bus.START) nxt = S_ARM;
            end
            state[I_ARM]: begin
                if (abort_eff || scnt_q == '0) begin
                    nxt = S_FINISH;
                end else begin
                    nxt      = S_LAUNCH;
                    cnt_load = 1'b1;
                    cnt_val  = TMO_LOAD;
                end
            end
            state[I_LAUNCH]: begin
                if (bus.PP_FSMSTAT)          nxt = S_RUN;
                else if (abort_eff || cnt_zero) nxt = S_FINISH;
                else                         cnt_dec = 1'b1;
            end
            state[I_RUN]: begin
                if (!bus.PP_FSMSTAT) begin
                    nxt      = S_REPDLY;
                    cnt_load = 1'b1;
                    cnt_val  = rdly_q;
                end
            end
            state[I_REPDLY]: begin
                if (cnt_zero) nxt = S_NEXT;
                else          cnt_dec = 1'b1;
            end
            state[I_NEXT]: begin
                if (last_scan || abort_eff) begin
                    nxt = S_FINISH;
                end else begin
                    nxt      = S_LAUNCH;
                    cnt_load = 1'b1;
                    cnt_val  = TMO_LOAD;
                end
            end
            state[I_FINISH]: nxt = S_IDLE;
            default:         nxt = S_IDLE;
        endcase
    end

    // run parameters, scan index, status and engine outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            scnt_q     <= '0;
            rdly_q     <= '0;
            phen_q     <= 1'b0;
            idx_q      <= '0;
            phase_q    <= 1'b0;
            pp_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            pp_start_q <= (nxt == S_LAUNCH);
            if (state[I_IDLE] && bus.START) begin
                scnt_q    <= bus.SCAN_COUNT;
                rdly_q    <= bus.REP_DELAY;
                phen_q    <= bus.PHCYC_EN;
                idx_q     <= '0;
                phase_q   <= 1'b0;
                aborted_q <= 1'b0;
                tmo_err_q <= 1'b0;
                abort_q   <= 1'b0;
                busy_q    <= 1'b1;
            end
            if (state[I_NEXT] && nxt == S_LAUNCH) begin
                idx_q <= idx_q + W'(1);
                if (phen_q) phase_q <= ~phase_q;
            end
            if (state[I_LAUNCH] && nxt == S_FINISH && !abort_eff) begin
                tmo_err_q <= 1'b1;
            end
            if (nxt == S_FINISH) begin
                done_q    <= 1'b1;
                busy_q    <= 1'b0;
                aborted_q <= abort_eff;
                abort_q   <= 1'b0;
            end else if (!state[I_IDLE] && !state[I_FINISH] && bus.ABORT) begin
                abort_q <= 1'b1;
            end
        end
    end

    assign bus.PP_START    = pp_start_q;
    assign bus.PHASE_CYC   = phase_q;
    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.ABORTED     = aborted_q;
    assign bus.TIMEOUT_ERR = tmo_err_q;
    assign bus.SCAN_IDX    = idx_q;

endmodule
